// File: rtl/decoder_2_to_4_sync.sv
// Registered, flow-controlled binary-to-one-hot decoder with a 2-entry output queue.
// Optional per-output hit counters are built only when DECODER_HIT_CNT_EN is defined.
module decoder_2_to_4_sync #(
   parameter int N = 2
`ifdef DECODER_HIT_CNT_EN
   ,
   parameter int CNT_W = 8
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0]        A,
   input  logic                en,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [(2**N)-1:0]   out
`ifdef DECODER_HIT_CNT_EN
   ,
   output logic [CNT_W*(2**N)-1:0] hit_cnt
`endif
);

   localparam int OUT_W = 2**N;
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;
   localparam logic [OUT_W-1:0] LSB_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

   function automatic logic [OUT_W-1:0] decode(input logic [N-1:0] code, input logic enable);
      logic [OUT_W-1:0] word;
      if (enable) begin
         word = LSB_ONE << code;
      end else begin
         word = {OUT_W{1'b0}};
      end
      return word;
   endfunction

   logic [1:0]       state_r;
   logic [1:0]       state_s;
   logic [OUT_W-1:0] head_r;
   logic [OUT_W-1:0] head_s;
   logic [OUT_W-1:0] tail_r;
   logic [OUT_W-1:0] tail_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             push_s;
   logic             pop_s;
   logic [OUT_W-1:0] word_s;

   assign push_s    = in_valid & in_ready_r;
   assign pop_s     = out_valid_r & out_ready;
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out       = head_r;

   // Queue next-state: head is the visible word, tail is the skid slot
   always_comb begin
      state_s = state_r;
      head_s  = head_r;
      tail_s  = tail_r;
      word_s  = decode(A, en);
      case (state_r)
         ST_EMPTY: begin
            if (push_s) begin
               state_s = ST_ONE;
               head_s  = word_s;
            end else begin
               state_s = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (push_s && pop_s) begin
               head_s = word_s;
            end else if (push_s) begin
               state_s = ST_TWO;
               tail_s  = word_s;
            end else if (pop_s) begin
               state_s = ST_EMPTY;
            end else begin
               state_s = ST_ONE;
            end
         end
         ST_TWO: begin
            if (pop_s) begin
               state_s = ST_ONE;
               head_s  = tail_r;
            end else begin
               state_s = ST_TWO;
            end
         end
         default: begin
            state_s = ST_EMPTY;
         end
      endcase
   end

   // Queue registers; handshake flags are registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         head_r      <= {OUT_W{1'b0}};
         tail_r      <= {OUT_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         head_r      <= head_s;
         tail_r      <= tail_s;
         in_ready_r  <= (state_s != ST_TWO);
         out_valid_r <= (state_s != ST_EMPTY);
      end
   end

`ifdef DECODER_HIT_CNT_EN
   logic [CNT_W-1:0] cnt_r [OUT_W];

   // Saturating per-output counters, stepped when a word leaves the queue
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < OUT_W; k++) begin
            cnt_r[k] <= {CNT_W{1'b0}};
         end
      end else begin
         for (int k = 0; k < OUT_W; k++) begin
            if (pop_s && head_r[k] && (cnt_r[k] != {CNT_W{1'b1}})) begin
               cnt_r[k] <= cnt_r[k] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               cnt_r[k] <= cnt_r[k];
            end
         end
      end
   end

   for (genvar g = 0; g < OUT_W; g++) begin : g_hit
      assign hit_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
   end
`endif

endmodule
